ship_life_ctl: RTL and testbench

SHIP_LIFE_CTL -- requirements
Module: ship_life_ctl

---
 rtl/ship_life_ctl.sv | 174 +++++++++++++++++
 tb/tb_ship_life_ctl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ship_life_ctl.sv
// Player ship life-cycle controller: ALIVE -> DEAD -> INVULN -> ALIVE, with GAME_OVER once lives run out.
// All outputs are registered from the next-state values, so they update on the same edge as the state.
module ship_life_ctl #(
  parameter int LIVES         = 3,
  parameter int DEAD_FRAMES   = 60,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hit,
  input  logic       frame_tick,
  input  logic       restart,
  output logic [1:0] state_out,
  output logic       ship_dead,
  output logic       ship_visible,
  output logic       invuln,
  output logic       game_over,
  output logic [3:0] dead_count,
  output logic       hit_ack
);

  localparam logic [1:0] S_ALIVE     = 2'd0;
  localparam logic [1:0] S_DEAD      = 2'd1;
  localparam logic [1:0] S_INVULN    = 2'd2;
  localparam logic [1:0] S_GAME_OVER = 2'd3;

  // Limits are clamped into 1..255 so an out-of-range parameter saturates instead of wrapping.
  localparam int DEAD_I   = (DEAD_FRAMES < 1)   ? 1 : (DEAD_FRAMES > 255)   ? 255 : DEAD_FRAMES;
  localparam int INVULN_I = (INVULN_FRAMES < 1) ? 1 : (INVULN_FRAMES > 255) ? 255 : INVULN_FRAMES;
  localparam int BLINK_I  = (BLINK_FRAMES < 1)  ? 1 : (BLINK_FRAMES > 255)  ? 255 : BLINK_FRAMES;
  localparam int LIVES_I  = (LIVES < 1)         ? 1 : (LIVES > 15)          ? 15  : LIVES;

  localparam logic [7:0] DEAD_LIM   = 8'(DEAD_I);
  localparam logic [7:0] INVULN_LIM = 8'(INVULN_I);
  localparam logic [7:0] BLINK_LIM  = 8'(BLINK_I);
  localparam logic [3:0] LIVES_L    = 4'(LIVES_I);

  logic [1:0] r_state;
  logic [3:0] r_lives;
  logic [7:0] r_frame;
  logic [7:0] r_blink;
  logic       r_blink_ph;
  logic       r_hit_q;
  logic       r_hit_arm;
  logic       r_restart_q;

  logic       w_hit_evt;
  logic       w_restart_evt;
  logic [7:0] w_frame_inc;
  logic [7:0] w_blink_inc;
  logic [1:0] w_state_nx;
  logic [3:0] w_lives_nx;
  logic [7:0] w_frame_nx;
  logic [7:0] w_blink_nx;
  logic       w_phase_nx;
  logic       w_ack_nx;

  // r_hit_arm stays low until hit is seen low, so a hit held through reset release is not an edge.
  assign w_hit_evt     = hit & ~r_hit_q & r_hit_arm;
  assign w_restart_evt = restart & ~r_restart_q;
  assign w_frame_inc   = (r_frame == 8'hFF) ? 8'hFF : r_frame + 8'd1;
  assign w_blink_inc   = (r_blink == 8'hFF) ? 8'hFF : r_blink + 8'd1;

  always_comb begin
    w_state_nx = r_state;
    w_lives_nx = r_lives;
    w_frame_nx = r_frame;
    w_blink_nx = r_blink;
    w_phase_nx = r_blink_ph;
    w_ack_nx   = 1'b0;
    case (r_state)
      S_ALIVE: begin
        // A hit wins over a coincident frame_tick; ALIVE has no frame count anyway.
        if (w_hit_evt) begin
          w_ack_nx   = 1'b1;
          w_lives_nx = (r_lives != 4'd0) ? r_lives - 4'd1 : 4'd0;
          w_state_nx = (r_lives <= 4'd1) ? S_GAME_OVER : S_DEAD;
          w_frame_nx = 8'd0;
          w_blink_nx = 8'd0;
          w_phase_nx = 1'b0;
        end
      end
      S_DEAD: begin
        if (frame_tick) begin
          if (w_frame_inc >= DEAD_LIM) begin
            w_state_nx = S_INVULN;
            w_frame_nx = 8'd0;
            w_blink_nx = 8'd0;
            w_phase_nx = 1'b0;
          end else begin
            w_frame_nx = w_frame_inc;
          end
        end
      end
      S_INVULN: begin
        if (frame_tick) begin
          if (w_frame_inc >= INVULN_LIM) begin
            w_state_nx = S_ALIVE;
            w_frame_nx = 8'd0;
            w_blink_nx = 8'd0;
            w_phase_nx = 1'b0;
          end else begin
            w_frame_nx = w_frame_inc;
            if (w_blink_inc >= BLINK_LIM) begin
              w_blink_nx = 8'd0;
              w_phase_nx = ~r_blink_ph;
            end else begin
              w_blink_nx = w_blink_inc;
            end
          end
        end
      end
      S_GAME_OVER: begin
        if (w_restart_evt) begin
          w_state_nx = S_ALIVE;
          w_lives_nx = LIVES_L;
          w_frame_nx = 8'd0;
          w_blink_nx = 8'd0;
          w_phase_nx = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_ALIVE;
        w_frame_nx = 8'd0;
        w_blink_nx = 8'd0;
        w_phase_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_ALIVE;
      r_lives     <= LIVES_L;
      r_frame     <= 8'd0;
      r_blink     <= 8'd0;
      r_blink_ph  <= 1'b0;
      r_hit_q     <= 1'b0;
      r_hit_arm   <= 1'b0;
      r_restart_q <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_lives     <= w_lives_nx;
      r_frame     <= w_frame_nx;
      r_blink     <= w_blink_nx;
      r_blink_ph  <= w_phase_nx;
      r_hit_q     <= hit;
      r_hit_arm   <= r_hit_arm | ~hit;
      r_restart_q <= restart;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ship_dead    <= 1'b0;
      ship_visible <= 1'b1;
      invuln       <= 1'b0;
      game_over    <= 1'b0;
      dead_count   <= 4'd0;
      hit_ack      <= 1'b0;
    end else begin
      ship_dead    <= (w_state_nx == S_DEAD) || (w_state_nx == S_GAME_OVER);
      ship_visible <= (w_state_nx == S_ALIVE) || ((w_state_nx == S_INVULN) && w_phase_nx);
      invuln       <= (w_state_nx == S_INVULN);
      game_over    <= (w_state_nx == S_GAME_OVER);
      dead_count   <= LIVES_L - w_lives_nx;
      hit_ack      <= w_ack_nx;
    end
  end

  assign state_out = r_state;

endmodule

// File: tb/tb_ship_life_ctl.sv
// Bench for ship_life_ctl: directed scenarios with literal expectations, then random stimulus,
// with every cycle compared against a frame-counting behavioural model.
module tb_ship_life_ctl;

  localparam int LIVES  = 3;
  localparam int DEADF  = 4;
  localparam int INVF   = 6;
  localparam int BLINKF = 2;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       hit = 1'b0;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] state_out;
  logic       ship_dead, ship_visible, invuln, game_over, hit_ack;
  logic [3:0] dead_count;

  int n_vec = 0;
  int n_err = 0;
  int n_ack = 0;

  // model state
  int m_state = 0;
  int m_lives = LIVES;
  int m_fcnt  = 0;
  int m_hprev = 0;
  int m_armed = 0;
  int m_rprev = 0;
  int m_ack   = 0;

  ship_life_ctl #(
    .LIVES(LIVES), .DEAD_FRAMES(DEADF), .INVULN_FRAMES(INVF), .BLINK_FRAMES(BLINKF)
  ) dut (
    .pclk(pclk), .rst(rst), .hit(hit), .frame_tick(frame_tick), .restart(restart),
    .state_out(state_out), .ship_dead(ship_dead), .ship_visible(ship_visible),
    .invuln(invuln), .game_over(game_over), .dead_count(dead_count), .hit_ack(hit_ack)
  );

  always #5 pclk = ~pclk;

  // behavioural model and per-cycle compare
  always @(posedge pclk) begin
    int evt, rev, e_dead, e_vis, e_inv, e_go, e_dc;
    if (!rst) begin
      m_state = 0; m_lives = LIVES; m_fcnt = 0;
      m_hprev = 0; m_armed = 0; m_rprev = 0; m_ack = 0;
    end else begin
      evt = (hit && !m_hprev && m_armed) ? 1 : 0;
      rev = (restart && !m_rprev) ? 1 : 0;
      m_ack = 0;
      if (m_state == 0) begin
        if (evt != 0) begin
          m_ack = 1;
          m_lives = m_lives - 1;
          m_state = (m_lives == 0) ? 3 : 1;
          m_fcnt = 0;
        end
      end else if (m_state == 1) begin
        if (frame_tick) begin
          m_fcnt++;
          if (m_fcnt == DEADF) begin m_state = 2; m_fcnt = 0; end
        end
      end else if (m_state == 2) begin
        if (frame_tick) begin
          m_fcnt++;
          if (m_fcnt == INVF) begin m_state = 0; m_fcnt = 0; end
        end
      end else begin
        if (rev != 0) begin m_state = 0; m_lives = LIVES; m_fcnt = 0; end
      end
      m_hprev = hit ? 1 : 0;
      if (!hit) m_armed = 1;
      m_rprev = restart ? 1 : 0;
    end
    #1;
    e_dead = (m_state == 1 || m_state == 3) ? 1 : 0;
    e_inv  = (m_state == 2) ? 1 : 0;
    e_go   = (m_state == 3) ? 1 : 0;
    e_vis  = (m_state == 0) ? 1 : (m_state == 2) ? ((m_fcnt / BLINKF) % 2) : 0;
    e_dc   = (LIVES - m_lives) & 15;
    n_vec++;
    if (int'(state_out) != m_state || int'(ship_dead) != e_dead || int'(ship_visible) != e_vis ||
        int'(invuln) != e_inv || int'(game_over) != e_go || int'(dead_count) != e_dc ||
        int'(hit_ack) != m_ack) begin
      n_err++;
      $display("FAIL model t=%0t got st=%0d dead=%0d vis=%0d inv=%0d go=%0d dc=%0d ack=%0d exp st=%0d dead=%0d vis=%0d inv=%0d go=%0d dc=%0d ack=%0d",
               $time, state_out, ship_dead, ship_visible, invuln, game_over, dead_count, hit_ack,
               m_state, e_dead, e_vis, e_inv, e_go, e_dc, m_ack);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic t, input logic r);
    @(negedge pclk);
    hit = h; frame_tick = t; restart = r;
    @(posedge pclk);
    #2;
    if (hit_ack) n_ack++;
  endtask

  initial begin
    int vis_exp[6] = '{0, 0, 1, 1, 0, 0};
    int hold_rst;
    repeat (3) @(negedge pclk);
    #1;
    chk("reset_state", int'(state_out), 0);
    chk("reset_visible", int'(ship_visible), 1);
    chk("reset_dead_count", int'(dead_count), 0);
    @(negedge pclk);
    rst = 1'b1;
    repeat (3) step(0, 0, 0);

    // single hit held high for five cycles
    repeat (5) step(1, 0, 0);
    step(0, 0, 0);
    chk("single_hit_acks", n_ack, 1);
    chk("single_hit_dead_count", int'(dead_count), 1);
    chk("single_hit_state", int'(state_out), 1);
    chk("single_hit_ship_dead", int'(ship_dead), 1);
    chk("single_hit_visible", int'(ship_visible), 0);

    // respawn timing with hit edges during DEAD and INVULN
    for (int i = 0; i < DEADF; i++) begin
      if (i == DEADF - 1) chk("dead_before_last_tick", int'(state_out), 1);
      step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    end
    chk("invuln_after_4th_tick", int'(state_out), 2);
    chk("invuln_flag", int'(invuln), 1);
    for (int f = 0; f < INVF; f++) begin
      chk($sformatf("blink_frame%0d", f), int'(ship_visible), vis_exp[f]);
      step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
    end
    chk("alive_after_6th_tick", int'(state_out), 0);
    chk("alive_visible", int'(ship_visible), 1);
    chk("immunity_acks", n_ack, 1);
    chk("immunity_dead_count", int'(dead_count), 1);

    // hit edge and frame_tick together in ALIVE
    step(1, 1, 0);
    step(0, 0, 0);
    chk("same_cycle_state", int'(state_out), 1);
    chk("same_cycle_dead_count", int'(dead_count), 2);
    for (int i = 0; i < DEADF - 1; i++) begin step(0, 1, 0); step(0, 0, 0); end
    chk("same_cycle_counter_from_zero", int'(state_out), 1);
    step(0, 1, 0);
    chk("same_cycle_invuln", int'(state_out), 2);
    for (int i = 0; i < INVF; i++) begin step(0, 1, 0); step(0, 0, 0); end
    step(0, 0, 1); step(0, 0, 0);
    chk("restart_in_alive_state", int'(state_out), 0);
    chk("restart_in_alive_dead_count", int'(dead_count), 2);

    // game over and restart
    step(1, 0, 0);
    chk("game_over_flag", int'(game_over), 1);
    chk("game_over_state", int'(state_out), 3);
    chk("game_over_dead_count", int'(dead_count), 3);
    chk("game_over_visible", int'(ship_visible), 0);
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("game_over_acks", n_ack, 3);
    step(0, 0, 1);
    chk("restart_state", int'(state_out), 0);
    chk("restart_dead_count", int'(dead_count), 0);
    chk("restart_visible", int'(ship_visible), 1);
    chk("restart_game_over", int'(game_over), 0);
    step(0, 0, 0);

    // reset in the middle of INVULN with hit held high through release
    step(1, 0, 0); step(0, 0, 0);
    for (int i = 0; i < DEADF + 2; i++) begin step(0, 1, 0); step(0, 0, 0); end
    chk("pre_reset_invuln", int'(state_out), 2);
    step(1, 0, 0);
    @(negedge pclk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_state", int'(state_out), 0);
    chk("async_reset_visible", int'(ship_visible), 1);
    chk("async_reset_invuln", int'(invuln), 0);
    chk("async_reset_dead_count", int'(dead_count), 0);
    chk("async_reset_ship_dead", int'(ship_dead), 0);
    step(1, 0, 0); step(1, 0, 0);
    @(negedge pclk);
    rst = 1'b1;
    repeat (4) step(1, 0, 0);
    chk("held_hit_no_ack", n_ack, 4);
    step(0, 0, 0); step(1, 0, 0);
    chk("retoggled_hit_ack", n_ack, 5);
    chk("retoggled_hit_state", int'(state_out), 1);
    step(0, 0, 0);

    // random stimulus, model compare only
    hold_rst = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge pclk);
      if ($urandom_range(0, 3) == 0) hit = ~hit;
      frame_tick = ($urandom_range(0, 2) == 0);
      restart = ($urandom_range(0, 5) == 0);
      if (hold_rst > 0) begin
        hold_rst--;
        rst = (hold_rst == 0);
      end else if ($urandom_range(0, 599) == 0) begin
        hold_rst = $urandom_range(1, 3);
        rst = 1'b0;
      end
    end
    @(negedge pclk);
    rst = 1'b1; hit = 1'b0; frame_tick = 1'b0; restart = 1'b0;
    repeat (3) @(negedge pclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
